flash_fetch_unit: RTL

Instruction fetch front-end that sits directly downstream of the QSPI flash byte reader and upstream of the core. It drives the reader's address, read-from-address and read-next controls, assembles four sequential bytes into a little-endian 32-bit instruction word, and offers the word to the core over a valid/ready handshake. A redirect input (jump or branch) abandons the word in progress and restarts the flash stream at a new address.

---
 rtl/flash_fetch_pkg.sv | 17 +
 rtl/rise_detect.sv | 21 ++
 rtl/flash_fetch_unit.sv | 122 ++++++++++++
 3 files changed

// File: rtl/flash_fetch_pkg.sv
// Shared widths, fetch state encoding and address helper for the flash fetch front-end.
package flash_fetch_pkg;

    localparam int ADDR_W     = 24;
    localparam int WORD_BYTES = 4;

    typedef enum logic [1:0] {
        START   = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } fetch_state_t;

    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/rise_detect.sv
// One-bit registered rising-edge detector; rise is high in the cycle the input goes 0 -> 1.
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic d_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            d_reg <= 1'b0;
        end else begin
            d_reg <= d;
        end
    end

    assign rise = d & ~d_reg;

endmodule

// File: rtl/flash_fetch_unit.sv
// Instruction fetch front-end: steers the QSPI byte reader, packs four bytes little-endian
// into a 32-bit word and hands it to the core over valid/ready; redirect restarts the stream.
module flash_fetch_unit
    import flash_fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_ADDR = 24'h000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] instr_addr,
    output logic [ADDR_W-1:0] flash_addr,
    output logic              flash_read_from_addr,
    output logic              flash_read_next,
    input  logic              flash_data_ready,
    input  logic [7:0]        flash_data
);

    fetch_state_t      state_reg;
    fetch_state_t      state_next;
    logic [1:0]        idx_reg;
    logic [7:0]        lane_reg [WORD_BYTES];
    logic [ADDR_W-1:0] instr_addr_reg;
    logic [ADDR_W-1:0] flash_addr_reg;
    logic              valid_reg;
    logic              read_next_reg;
    logic              strobe_edge;
    logic              capture;
    logic              accept;

    rise_detect u_strobe_rise (
        .clk  (clk),
        .rst  (rst),
        .d    (flash_data_ready),
        .rise (strobe_edge)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= START;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (redirect) begin
            state_next = START;
        end else begin
            case (state_reg)
                START:   state_next = COLLECT;
                COLLECT: if (capture && idx_reg == 2'd3) state_next = HOLD;
                HOLD:    if (accept) state_next = COLLECT;
                default: state_next = START;
            endcase
        end
    end

    // The restart pulse is suppressed while reset is held so nothing leaks to the reader.
    always_comb begin
        flash_read_from_addr = (state_reg == START) && rst;
        capture              = (state_reg == COLLECT) && strobe_edge && !redirect;
        accept               = (state_reg == HOLD) && valid_reg && instr_ready && !redirect;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_reg        <= 2'd0;
            valid_reg      <= 1'b0;
            read_next_reg  <= 1'b0;
            instr_addr_reg <= RESET_ADDR;
            flash_addr_reg <= RESET_ADDR;
        end else begin
            read_next_reg <= 1'b0;
            if (redirect) begin
                idx_reg        <= 2'd0;
                valid_reg      <= 1'b0;
                instr_addr_reg <= word_align(redirect_addr);
                flash_addr_reg <= word_align(redirect_addr);
            end else begin
                if (capture) begin
                    idx_reg <= idx_reg + 2'd1;
                    if (idx_reg == 2'd3) begin
                        valid_reg <= 1'b1;
                    end else begin
                        read_next_reg <= 1'b1;
                    end
                end
                if (accept) begin
                    valid_reg      <= 1'b0;
                    instr_addr_reg <= instr_addr_reg + ADDR_W'(WORD_BYTES);
                    read_next_reg  <= 1'b1;
                end
            end
        end
    end

    // Each byte lane only loads when the byte index points at it, so a held word stays frozen.
    generate
        for (genvar gi = 0; gi < WORD_BYTES; gi++) begin : g_lane
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    lane_reg[gi] <= 8'h00;
                end else if (capture && idx_reg == 2'(gi)) begin
                    lane_reg[gi] <= flash_data;
                end
            end
            assign instr[8*gi +: 8] = lane_reg[gi];
        end
    endgenerate

    assign instr_valid     = valid_reg;
    assign instr_addr      = instr_addr_reg;
    assign flash_addr      = flash_addr_reg;
    assign flash_read_next = read_next_reg;

endmodule
